mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 x 4-bit multiplexer datapath among 8 requesters.
- Picks one requester, drives the mux select, registers the selected 4-bit word and presents it downstream with a valid/ready handshake.
- Returns a one-cycle acknowledge to the winning requester.
- Sits between eight 4-bit producers and a single 4-bit consumer.

---
 rtl/mux8_rr_arbiter_pkg.sv | 19 +
 rtl/mux8_rr_arbiter_if.sv | 27 ++
 rtl/mux4x8to4_c.sv | 30 +++
 rtl/mux8_rr_arbiter_rr_pick8.sv | 28 ++
 rtl/mux8_rr_arbiter.sv | 93 +++++++++
 tb/tb_mux8_rr_arbiter.sv | 194 +++++++++++++++++++
 6 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and sizes for the round-robin 8:1 mux arbiter.
package mux8_rr_arbiter_pkg;

  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester/consumer bus of the round-robin mux arbiter.
interface mux8_rr_arbiter_if #(parameter int CNT_W = 8);
  import mux8_rr_arbiter_pkg::*;

  logic                en;
  logic [N_REQ-1:0]    req;
  logic [DATA_W-1:0]   in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7;
  logic                out_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [SEL_W-1:0]    select;
  logic [N_REQ-1:0]    ack;
  logic                busy;
  logic [CNT_W-1:0]    xfer_count;

  // The arbiter itself sees the bus through the slave view.
  modport slave (
    input  en, req, in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7, out_ready,
    output out_valid, out_data, select, ack, busy, xfer_count
  );

  modport master (
    output en, req, in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7, out_ready,
    input  out_valid, out_data, select, ack, busy, xfer_count
  );

endinterface

// File: rtl/mux4x8to4_c.sv
// Combinational 8:1 multiplexer of 4-bit words.
module mux4x8to4_c (
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic [3:0] d7,
  input  logic [2:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      3'd0: y = d0;
      3'd1: y = d1;
      3'd2: y = d2;
      3'd3: y = d3;
      3'd4: y = d4;
      3'd5: y = d5;
      3'd6: y = d6;
      3'd7: y = d7;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating-priority search: first set request at or after ptr, wrapping 7->0.
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any_req
);

  always_comb begin
    logic [SEL_W-1:0] idx;
    logic             found;
    grant   = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Index arithmetic is SEL_W wide so the search wraps for free.
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 x 4-bit mux among eight requesters,
// with a registered valid/ready output and a one-cycle ack to the winner.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  mux8_rr_arbiter_if.slave   bus
);

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  select_q;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  next_sel;
  logic              any_req;
  logic              arb;
  logic [DATA_W-1:0] mux_out;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic [N_REQ-1:0]  ack_q;
  logic [CNT_W-1:0]  count_q;

  rr_pick8 u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .grant   (grant_idx),
    .any_req (any_req)
  );

  assign arb      = (state == IDLE) && bus.en && any_req;
  assign next_sel = arb ? grant_idx : select_q;

  // The mux looks at the select we are about to register, so the word
  // captured at the grant edge belongs to the new winner.
  mux4x8to4_c u_mux (
    .d0  (bus.in_0),
    .d1  (bus.in_1),
    .d2  (bus.in_2),
    .d3  (bus.in_3),
    .d4  (bus.in_4),
    .d5  (bus.in_5),
    .d6  (bus.in_6),
    .d7  (bus.in_7),
    .sel (next_sel),
    .y   (mux_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      select_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
      count_q  <= '0;
    end else begin
      ack_q <= '0;
      if (state == IDLE) begin
        if (arb) begin
          select_q <= grant_idx;
          data_q   <= mux_out;
          valid_q  <= 1'b1;
          busy_q   <= 1'b1;
          state    <= GRANT;
        end
      end else begin
        // Served requester drops to lowest priority on the next search.
        if (valid_q && bus.out_ready) begin
          ack_q    <= sel_onehot(select_q);
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
          ptr      <= select_q + SEL_W'(1);
          count_q  <= count_q + CNT_W'(1);
          state    <= IDLE;
        end
      end
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.select     = select_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;
  assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter.
module tb_mux8_rr_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   assertCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter_if #(.CNT_W(8)) bus();

  mux8_rr_arbiter #(.CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] reqv, input logic env, input logic readyv);
    bus.req       = reqv;
    bus.en        = env;
    bus.out_ready = readyv;
  endtask

  task automatic setDefaultData();
    bus.in_0 = 4'h0; bus.in_1 = 4'h1; bus.in_2 = 4'h2; bus.in_3 = 4'h3;
    bus.in_4 = 4'h4; bus.in_5 = 4'h5; bus.in_6 = 4'h6; bus.in_7 = 4'h7;
  endtask

  task automatic applyReset();
    applyStimulus(8'h00, 1'b1, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Precondition: just after a negedge, arbiter idle. Leaves req=0.
  task automatic transferOne(input logic [7:0] reqv, input int expSel, input logic [3:0] expData, input string tag);
    logic [7:0] oh;
    oh = 8'h01 << expSel;
    applyStimulus(reqv, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, " select"}, 32'(bus.select), 32'(expSel));
    checkOutput({tag, " data"}, 32'(bus.out_data), 32'(expData));
    applyStimulus(8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput({tag, " ack"}, 32'(bus.ack), 32'(oh));
    checkOutput({tag, " valid low"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] oh;
    setDefaultData();
    applyStimulus(8'hFF, 1'b1, 1'b0);
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst ack", 32'(bus.ack), 32'd0);
    checkOutput("rst select", 32'(bus.select), 32'd0);
    checkOutput("rst count", 32'(bus.xfer_count), 32'd0);
    checkOutput("rst busy", 32'(bus.busy), 32'd0);
    checkOutput("rst data", 32'(bus.out_data), 32'd0);

    reset_n = 1'b1;
    applyStimulus(8'h01, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("first valid", 32'(bus.out_valid), 32'd1);
    checkOutput("first select", 32'(bus.select), 32'd0);
    checkOutput("first data", 32'(bus.out_data), 32'd0);
    checkOutput("first busy", 32'(bus.busy), 32'd1);
    applyStimulus(8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("first ack", 32'(bus.ack), 32'h01);
    checkOutput("first count", 32'(bus.xfer_count), 32'd1);

    $display("[TB] rotation");
    applyReset();
    applyStimulus(8'hFF, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      oh = 8'h01 << (k % 8);
      @(negedge clk);
      checkOutput("rot valid", 32'(bus.out_valid), 32'd1);
      checkOutput("rot select", 32'(bus.select), 32'(k % 8));
      checkOutput("rot data", 32'(bus.out_data), 32'(k % 8));
      @(negedge clk);
      checkOutput("rot ack", 32'(bus.ack), 32'(oh));
      checkOutput("rot gap", 32'(bus.out_valid), 32'd0);
    end
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("rot count", 32'(bus.xfer_count), 32'd9);

    $display("[TB] backpressure");
    applyStimulus(8'h20, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp select", 32'(bus.select), 32'd5);
    checkOutput("bp data", 32'(bus.out_data), 32'h5);
    bus.in_5 = 4'hA;
    bus.req  = 8'h01;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("bp hold data", 32'(bus.out_data), 32'h5);
      checkOutput("bp hold select", 32'(bus.select), 32'd5);
      checkOutput("bp hold ack", 32'(bus.ack), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp ack", 32'(bus.ack), 32'h20);
    checkOutput("bp valid low", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("bp ack one cycle", 32'(bus.ack), 32'd0);
    checkOutput("bp next select", 32'(bus.select), 32'd0);
    checkOutput("bp next data", 32'(bus.out_data), 32'h0);
    applyStimulus(8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("bp next ack", 32'(bus.ack), 32'h01);
    bus.in_5 = 4'h5;

    $display("[TB] wrap priority");
    transferOne(8'h40, 6, 4'h6, "serve6");
    transferOne(8'h41, 0, 4'h0, "after6");
    transferOne(8'h41, 6, 4'h6, "after0");

    $display("[TB] enable gating");
    applyStimulus(8'h0F, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("en low valid", 32'(bus.out_valid), 32'd0);
    end
    bus.en = 1'b1;
    @(negedge clk);
    checkOutput("en grant valid", 32'(bus.out_valid), 32'd1);
    checkOutput("en grant select", 32'(bus.select), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("en drop valid", 32'(bus.out_valid), 32'd1);
    checkOutput("en drop busy", 32'(bus.busy), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("en drop ack", 32'(bus.ack), 32'h01);
    bus.en = 1'b1;
    checkOutput("en count", 32'(bus.xfer_count), 32'd15);

    $display("[TB] counter wrap");
    applyReset();
    applyStimulus(8'h01, 1'b1, 1'b1);
    repeat (510) @(negedge clk);
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("count 255", 32'(bus.xfer_count), 32'd255);
    checkOutput("count idle", 32'(bus.out_valid), 32'd0);
    transferOne(8'h01, 0, 4'h0, "wrap xfer");
    checkOutput("count wrapped", 32'(bus.xfer_count), 32'd0);
    transferOne(8'h01, 0, 4'h0, "pre-reset xfer");
    checkOutput("count one", 32'(bus.xfer_count), 32'd1);

    $display("[TB] reset mid-grant");
    applyStimulus(8'h08, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("mid valid", 32'(bus.out_valid), 32'd1);
    checkOutput("mid select", 32'(bus.select), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async busy", 32'(bus.busy), 32'd0);
    checkOutput("async select", 32'(bus.select), 32'd0);
    checkOutput("async count", 32'(bus.xfer_count), 32'd0);
    checkOutput("async data", 32'(bus.out_data), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst hold ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
    checkOutput("rst hold ack2", 32'(bus.ack), 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post rst ack", 32'(bus.ack), 32'd0);
    transferOne(8'h81, 0, 4'h0, "post-reset");
    checkOutput("post rst count", 32'(bus.xfer_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
